// File: rtl/decode_pkg.sv
// Shared decode definitions for the decode stage.
// Opcodes, result/immediate selects, ALU ops and the control bundle.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
    logic       JalrSel;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // sltu folds onto slt and sra onto srl: only 3 ALU bits
  function automatic logic [2:0] alu_sel(
    input logic [2:0] f3,
    input logic       sub
  );
    logic [2:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = sub ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLT;
      3'b100: op = ALU_XOR;
      3'b101: op = ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_ctrl.sv
// Control decoder: opcode/funct3/funct7[5] -> control bundle + ImmSrc.
// Ports: op_i, funct3_i, funct7b5_i in; ctrl_o, imm_src_o out.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ctrl_t      ctrl_o,
  output logic [2:0] imm_src_o
);

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    imm_src_o = IMM_I;
    unique case (op_i)
      OP_LOAD: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.ResultSrc = RES_MEM;
        ctrl_o.ALUSrc    = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.MemWrite = 1'b1;
        ctrl_o.ALUSrc   = 1'b1;
        imm_src_o       = IMM_S;
      end
      OP_OPIMM: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.ALUSrc     = 1'b1;
        ctrl_o.ALUControl = alu_sel(funct3_i, 1'b0);
      end
      OP_OP: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.ALUControl = alu_sel(funct3_i, funct7b5_i);
      end
      OP_BRANCH: begin
        ctrl_o.Branch     = 1'b1;
        ctrl_o.ALUControl = ALU_SUB;
        imm_src_o         = IMM_B;
      end
      OP_JAL: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.Jump      = 1'b1;
        ctrl_o.ResultSrc = RES_PC4;
        imm_src_o        = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.Jump      = 1'b1;
        ctrl_o.JalrSel   = 1'b1;
        ctrl_o.ALUSrc    = 1'b1;
        ctrl_o.ResultSrc = RES_PC4;
      end
      OP_LUI: begin
        ctrl_o.RegWrite  = 1'b1;
        ctrl_o.ResultSrc = RES_IMM;
        imm_src_o        = IMM_U;
      end
      default: begin
        ctrl_o    = CTRL_BUBBLE;
        imm_src_o = IMM_I;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: control decode, regfile, immediates, load-use hazard,
// ID/EX register and saturating stall/bubble counters.
// In: clk, rst, InstrD, PCD, PCPlus4D, ValidD, FlushE, RdW/RegWriteW/ResultW.
// Out: StallD (comb), registered *E fields, ValidE, a0, StallCnt, BubbleCnt.
// Option: WB_BYPASS_EN makes same-cycle write-back visible on reads and a0.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               InstrD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic                      ValidD,
  input  logic                      FlushE,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic                      StallD,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic                      ALUSrcE,
  output logic                      JalrSelE,
  output logic [1:0]                ResultSrcE,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic                      ValidE,
  output logic [DATA_WIDTH-1:0]     a0,
  output logic [CNT_WIDTH-1:0]      StallCnt,
  output logic [CNT_WIDTH-1:0]      BubbleCnt
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] A0_IDX = REG_ADDR_WIDTH'(10);

  logic [REG_ADDR_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
  assign rs1_idx = REG_ADDR_WIDTH'(InstrD[19:15]);
  assign rs2_idx = REG_ADDR_WIDTH'(InstrD[24:20]);
  assign rd_idx  = REG_ADDR_WIDTH'(InstrD[11:7]);

  ctrl_t      ctrl_dec;
  logic [2:0] imm_src;

  decode_ctrl u_ctrl (
    .op_i       (InstrD[6:0]),
    .funct3_i   (InstrD[14:12]),
    .funct7b5_i (InstrD[30]),
    .ctrl_o     (ctrl_dec),
    .imm_src_o  (imm_src)
  );

  // immediate
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_ext;

  always_comb begin
    imm32 = '0;
    unique case (imm_src)
      IMM_I: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                      InstrD[11:8], 1'b0};
      IMM_J: imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                      InstrD[30:21], 1'b0};
      IMM_U: imm32 = {InstrD[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = DATA_WIDTH'($signed(imm32));

  // register file, x0 never written and read as 0
  logic [DATA_WIDTH-1:0] rf_q [NREG];
  logic                  wb_en;
  logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2;

  assign wb_en = RegWriteW & (RdW != '0);

  always_ff @(posedge clk) begin
    if (wb_en) rf_q[RdW] <= ResultW;
  end

  always_comb begin
    rf_rd1 = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    rf_rd2 = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
    a0     = rf_q[A0_IDX];
`ifdef WB_BYPASS_EN
    if (wb_en && (RdW == rs1_idx)) rf_rd1 = ResultW;
    if (wb_en && (RdW == rs2_idx)) rf_rd2 = ResultW;
    if (wb_en && (RdW == A0_IDX))  a0     = ResultW;
`endif
  end

  // ID/EX state
  ctrl_t                     ctrl_q, ctrl_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     rd1_q, rd1_d, rd2_q, rd2_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d, pc4_q, pc4_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rdx_q, rdx_d;
  logic [CNT_WIDTH-1:0]      scnt_q, scnt_d, bcnt_q, bcnt_d;
  logic                      bubble;

  // load in EX whose rd matches either decode source (used or not)
  assign StallD = ValidD & valid_q & ctrl_q.RegWrite
                & (ctrl_q.ResultSrc == RES_MEM) & (rdx_q != '0)
                & ((rdx_q == rs1_idx) | (rdx_q == rs2_idx));

  assign bubble = FlushE | StallD;

  always_comb begin
    ctrl_d  = ValidD ? ctrl_dec : CTRL_BUBBLE;
    valid_d = ValidD;
    rd1_d   = rf_rd1;
    rd2_d   = rf_rd2;
    imm_d   = imm_ext;
    pc_d    = PCD;
    pc4_d   = PCPlus4D;
    rs1_d   = rs1_idx;
    rs2_d   = rs2_idx;
    rdx_d   = rd_idx;
    if (bubble) begin
      ctrl_d  = CTRL_BUBBLE;
      valid_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      pc4_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rdx_d   = '0;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    bcnt_d = bcnt_q;
    if (StallD && (scnt_q != '1)) scnt_d = scnt_q + 1'b1;
    if (bubble && (bcnt_q != '1)) bcnt_d = bcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rdx_q   <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rdx_q   <= rdx_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rdx_q;
  assign RegWriteE   = ctrl_q.RegWrite;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign JumpE       = ctrl_q.Jump;
  assign BranchE     = ctrl_q.Branch;
  assign ALUSrcE     = ctrl_q.ALUSrc;
  assign JalrSelE    = ctrl_q.JalrSel;
  assign ResultSrcE  = ctrl_q.ResultSrc;
  assign ALUControlE = ALU_CTRL_WIDTH'(ctrl_q.ALUControl);
  assign ValidE      = valid_q;
  assign StallCnt    = scnt_q;
  assign BubbleCnt   = bcnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed cases plus random traffic
// against a cycle-level reference model (CNT_WIDTH=4 build).
module tb_decode_stage_pipe;
  import decode_pkg::*;

  localparam int CW = 4;
  localparam int CMAX = 2 ** CW - 1;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = '0;
  logic [31:0] PCD = '0;
  logic [31:0] PCPlus4D = '0;
  logic        ValidD = 1'b0;
  logic        FlushE = 1'b0;
  logic [4:0]  RdW = '0;
  logic        RegWriteW = 1'b0;
  logic [31:0] ResultW = '0;
  logic        StallD;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, a0;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrSelE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        ValidE;
  logic [CW-1:0] StallCnt, BubbleCnt;

  decode_stage_pipe #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FlushE(FlushE),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW),
    .StallD(StallD), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .JalrSelE(JalrSelE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .ValidE(ValidE), .a0(a0),
    .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] rf [32];
  bit          rf_known = 1'b0;
  logic        m_valid = 1'b0;
  ctrl_t       m_ctrl = '0;
  logic [31:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc = '0, m_pc4 = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  int          m_scnt = 0, m_bcnt = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctrl_t ref_ctrl(input logic [31:0] ins);
    ctrl_t c;
    logic [2:0] f3;
    logic [2:0] alu;
    c = '0;
    f3 = ins[14:12];
    case (f3)
      3'd0: alu = ALU_ADD;
      3'd1: alu = ALU_SLL;
      3'd2, 3'd3: alu = ALU_SLT;
      3'd4: alu = ALU_XOR;
      3'd5: alu = ALU_SRL;
      3'd6: alu = ALU_OR;
      default: alu = ALU_AND;
    endcase
    case (ins[6:0])
      OP_LOAD:   begin c.RegWrite = 1; c.ResultSrc = 2'b01; c.ALUSrc = 1; end
      OP_STORE:  begin c.MemWrite = 1; c.ALUSrc = 1; end
      OP_OPIMM:  begin c.RegWrite = 1; c.ALUSrc = 1; c.ALUControl = alu; end
      OP_OP: begin
        c.RegWrite = 1;
        c.ALUControl = (f3 == 0 && ins[30]) ? ALU_SUB : alu;
      end
      OP_BRANCH: begin c.Branch = 1; c.ALUControl = ALU_SUB; end
      OP_JAL:    begin c.RegWrite = 1; c.Jump = 1; c.ResultSrc = 2'b10; end
      OP_JALR: begin
        c.RegWrite = 1; c.Jump = 1; c.JalrSel = 1;
        c.ALUSrc = 1; c.ResultSrc = 2'b10;
      end
      OP_LUI:    begin c.RegWrite = 1; c.ResultSrc = 2'b11; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      OP_STORE:  v = $signed({ins[31:25], ins[11:7]});
      OP_BRANCH: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
      OP_JAL:    v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
      OP_LUI:    v = int'(ins[31:12]) * 4096;
      default:   v = $signed(ins[31:20]);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a,
      input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd);
    if (a == 0) return 32'h0;
    if (BYPASS && wbe && wbr == a) return wbd;
    return rf[a];
  endfunction

  task automatic check_all();
    check("ValidE", 64'(ValidE), 64'(m_valid));
    check("RegWriteE", 64'(RegWriteE), 64'(m_ctrl.RegWrite));
    check("ResultSrcE", 64'(ResultSrcE), 64'(m_ctrl.ResultSrc));
    check("MemWriteE", 64'(MemWriteE), 64'(m_ctrl.MemWrite));
    check("JumpE", 64'(JumpE), 64'(m_ctrl.Jump));
    check("BranchE", 64'(BranchE), 64'(m_ctrl.Branch));
    check("ALUSrcE", 64'(ALUSrcE), 64'(m_ctrl.ALUSrc));
    check("JalrSelE", 64'(JalrSelE), 64'(m_ctrl.JalrSel));
    check("ALUControlE", 64'(ALUControlE), 64'(m_ctrl.ALUControl));
    check("RD1E", 64'(RD1E), 64'(m_rd1));
    check("RD2E", 64'(RD2E), 64'(m_rd2));
    check("ImmExtE", 64'(ImmExtE), 64'(m_imm));
    check("PCE", 64'(PCE), 64'(m_pc));
    check("PCPlus4E", 64'(PCPlus4E), 64'(m_pc4));
    check("Rs1E", 64'(Rs1E), 64'(m_rs1));
    check("Rs2E", 64'(Rs2E), 64'(m_rs2));
    check("RdE", 64'(RdE), 64'(m_rd));
    check("StallCnt", 64'(StallCnt), 64'(m_scnt));
    check("BubbleCnt", 64'(BubbleCnt), 64'(m_bcnt));
    if (rf_known) check("a0", 64'(a0), 64'(rf[10]));
  endtask

  task automatic clear_e();
    m_valid = 0; m_ctrl = '0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    m_pc = 0; m_pc4 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  task automatic cycle(input logic r, input logic [31:0] ins,
      input logic vd, input logic fl, input logic wbe,
      input logic [4:0] wbr, input logic [31:0] wbd);
    logic stall;
    logic [4:0] s1, s2;
    logic [31:0] pc;
    @(negedge clk);
    pc = $urandom & ~32'h3;
    rst = r; InstrD = ins; ValidD = vd; FlushE = fl;
    RegWriteW = wbe; RdW = wbr; ResultW = wbd;
    PCD = pc; PCPlus4D = pc + 4;
    s1 = ins[19:15];
    s2 = ins[24:20];
    stall = vd && m_valid && m_ctrl.RegWrite && m_ctrl.ResultSrc == 2'b01
         && m_rd != 0 && (m_rd == s1 || m_rd == s2);
    #1;
    if (!r) check("StallD", 64'(StallD), 64'(stall));
    if (r) begin
      clear_e();
      m_scnt = 0;
      m_bcnt = 0;
    end else begin
      if (stall && m_scnt < CMAX) m_scnt++;
      if (fl || stall) begin
        clear_e();
        if (m_bcnt < CMAX) m_bcnt++;
      end else begin
        m_valid = vd;
        m_ctrl = vd ? ref_ctrl(ins) : '0;
        m_rd1 = rf_read(s1, wbe, wbr, wbd);
        m_rd2 = rf_read(s2, wbe, wbr, wbd);
        m_imm = ref_imm(ins);
        m_pc = pc; m_pc4 = pc + 4;
        m_rs1 = s1; m_rs2 = s2; m_rd = ins[11:7];
      end
    end
    if (wbe && wbr != 0) rf[wbr] = wbd;
    @(posedge clk);
    #1;
    check_all();
  endtask

  localparam logic [31:0] ADDI_X5 = 32'h0070_0293;
  localparam logic [31:0] LW_X6   = 32'h0000_A303;
  localparam logic [31:0] ADD_X7  = 32'h0023_03B3;
  localparam logic [31:0] ADDI_RD10 = 32'h0005_0593;
  localparam logic [31:0] ADDI_RD0  = 32'h0000_0093;

  initial begin
    logic [6:0] ops [10];
    logic [31:0] ins, old10;
    ops = '{OP_LOAD, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, 7'b1111111};
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // reset
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rst_StallD", 64'(StallD), 64'(0));

    // fill the register file
    for (int r = 1; r < 32; r++) cycle(0, 0, 0, 0, 1, 5'(r), $urandom);
    rf_known = 1'b1;

    // addi x5,x0,7
    cycle(0, ADDI_X5, 1, 0, 0, 0, 0);
    check("addi_RdE", 64'(RdE), 64'd5);
    check("addi_Imm", 64'(ImmExtE), 64'd7);

    // load-use
    cycle(0, LW_X6, 1, 0, 0, 0, 0);
    cycle(0, ADD_X7, 1, 0, 0, 0, 0);
    check("lu_ValidE", 64'(ValidE), 64'd0);
    check("lu_StallCnt", 64'(StallCnt), 64'd1);
    check("lu_BubbleCnt", 64'(BubbleCnt), 64'd1);
    cycle(0, ADD_X7, 1, 0, 0, 0, 0);
    check("lu_issue_RdE", 64'(RdE), 64'd7);

    // flush
    cycle(0, ADDI_X5, 1, 1, 0, 0, 0);
    check("fl_ValidE", 64'(ValidE), 64'd0);
    check("fl_BubbleCnt", 64'(BubbleCnt), 64'd2);
    check("fl_StallCnt", 64'(StallCnt), 64'd1);

    // write-back vs. read of x10
    old10 = rf[10];
    cycle(0, ADDI_RD10, 1, 0, 1, 5'd10, 32'hDEADBEEF);
    check("wb_RD1E", 64'(RD1E), BYPASS ? 64'hDEADBEEF : 64'(old10));
    check("wb_a0", 64'(a0), 64'hDEADBEEF);
    cycle(0, ADDI_RD0, 1, 0, 1, 5'd0, 32'h1234_5678);
    check("x0_RD1E", 64'(RD1E), 64'd0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 63) == 0), ins,
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
    end

    // counter saturation
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, LW_X6, 1, 0, 0, 0, 0);
      cycle(0, ADD_X7, 1, 0, 0, 0, 0);
      cycle(0, ADD_X7, 1, 0, 0, 0, 0);
    end
    check("sat_StallCnt", 64'(StallCnt), 64'hF);
    check("sat_BubbleCnt", 64'(BubbleCnt), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
